// File: rtl/pc_sequencer_if.sv
// Fetch-side control/status bundle between the decode/execute logic and the
// program-counter sequencer.
interface pc_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jump_reg;
  logic [31:0] extended;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect;
  logic        addr_error;

  // Decode side: presents the controls for the instruction at pc, observes the fetch state.
  modport master (
    output stall, branch_taken, jump, jump_reg, extended, reg_target,
    input  pc, npc, redirect, addr_error
  );

  // Sequencer side: samples the controls, owns pc/npc and the status flags.
  modport slave (
    input  stall, branch_taken, jump, jump_reg, extended, reg_target,
    output pc, npc, redirect, addr_error
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program-counter sequencer holding pc and npc so the delay slot at the
// old npc always executes before a control transfer takes effect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic        redirect_q;
  logic        addr_error_q;

  logic [31:0] target;
  logic        transfer;
  logic        misaligned;

  // Every fetch address is a word address; low two bits are forced clear.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Next-npc selection, priority jump_reg > jump > branch_taken > sequential.
  always_comb begin
    target     = npc_q + 32'd4;
    transfer   = 1'b0;
    misaligned = 1'b0;
    if (bus.jump_reg) begin
      target     = align_word(bus.reg_target);
      transfer   = 1'b1;
      misaligned = (bus.reg_target[1:0] != 2'b00);
    end else if (bus.jump) begin
      // Jump stays inside the 256 MB region of the delay-slot address.
      target   = align_word({npc_q[31:28], bus.extended[27:0]});
      transfer = 1'b1;
    end else if (bus.branch_taken) begin
      // Branch offset is relative to the delay slot, wrapping modulo 2^32.
      target   = align_word(npc_q + bus.extended);
      transfer = 1'b1;
    end
  end

  // Advance pc/npc each unstalled edge; status flags pulse for one cycle only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC + 32'd4;
      redirect_q   <= 1'b0;
      addr_error_q <= 1'b0;
    end else if (bus.stall) begin
      redirect_q   <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      pc_q         <= npc_q;
      npc_q        <= target;
      redirect_q   <= transfer;
      addr_error_q <= misaligned;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.npc        = npc_q;
  assign bus.redirect   = redirect_q;
  assign bus.addr_error = addr_error_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized control
// traffic, all compared against an architectural model of the fetch state.
module tb_pc_sequencer;

  logic clk;
  logic reset;

  pc_sequencer_if bus ();
  pc_sequencer_if bus_wrap ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Architectural model state
  logic [31:0] m_pc, m_npc;
  logic        m_redirect, m_addr_error;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Apply the architectural rules to the inputs about to be sampled.
  task automatic model_step();
    logic [31:0] tgt;
    bit          xfer, bad;
    if (!reset) begin
      m_pc = 32'h0040_0000;
      m_npc = 32'h0040_0004;
      m_redirect = 0;
      m_addr_error = 0;
    end else if (bus.stall) begin
      m_redirect = 0;
      m_addr_error = 0;
    end else begin
      xfer = 1;
      bad  = 0;
      if (bus.jump_reg) begin
        tgt = bus.reg_target - (bus.reg_target % 4);
        bad = (bus.reg_target % 4) != 0;
      end else if (bus.jump) begin
        tgt = (m_npc & 32'hF000_0000) + (bus.extended & 32'h0FFF_FFFC);
      end else if (bus.branch_taken) begin
        tgt = (m_npc + bus.extended) & 32'hFFFF_FFFC;
      end else begin
        tgt  = m_npc + 4;
        xfer = 0;
      end
      m_pc = m_npc;
      m_npc = tgt;
      m_redirect = xfer;
      m_addr_error = bad;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},         bus.pc,                 m_pc);
    chk({tag, ".npc"},        bus.npc,                m_npc);
    chk({tag, ".redirect"},   {31'd0, bus.redirect},   {31'd0, m_redirect});
    chk({tag, ".addr_error"}, {31'd0, bus.addr_error}, {31'd0, m_addr_error});
  endtask

  task automatic set_ctl(input logic st, input logic br, input logic j, input logic jr,
                         input logic [31:0] ext, input logic [31:0] rt);
    bus.stall = st;
    bus.branch_taken = br;
    bus.jump = j;
    bus.jump_reg = jr;
    bus.extended = ext;
    bus.reg_target = rt;
  endtask

  initial begin
    m_pc = '0; m_npc = '0; m_redirect = 0; m_addr_error = 0;
    bus_wrap.stall = 0; bus_wrap.branch_taken = 0; bus_wrap.jump = 0;
    bus_wrap.jump_reg = 0; bus_wrap.extended = '0; bus_wrap.reg_target = '0;

    // Reset held with jump and stall asserted
    reset = 0;
    set_ctl(1, 0, 1, 0, 32'h0000_0100, 32'h0);
    #2;
    tick();
    tick();
    chk("rst.pc", bus.pc, 32'h0040_0000);
    chk("rst.npc", bus.npc, 32'h0040_0004);
    check_model("rst");
    chk("wrap_rst.npc", bus_wrap.npc, 32'hFFFF_FFFC);

    // Sequential fetch
    reset = 1;
    set_ctl(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("seq1.pc", bus.pc, 32'h0040_0004);
    chk("wrap.pc", bus_wrap.pc, 32'hFFFF_FFFC);
    chk("wrap.npc", bus_wrap.npc, 32'h0000_0000);
    check_model("seq1");
    tick();
    chk("seq2.pc", bus.pc, 32'h0040_0008);

    // Backward branch at pc=0x0040_0008
    set_ctl(0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0);
    tick();
    chk("br.pc", bus.pc, 32'h0040_000C);
    chk("br.npc", bus.npc, 32'h0040_0004);
    chk("br.redirect", {31'd0, bus.redirect}, 32'd1);
    check_model("br");
    set_ctl(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("br2.pc", bus.pc, 32'h0040_0004);
    chk("br2.redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    tick();
    chk("pre_j.pc", bus.pc, 32'h0040_000C);

    // Jump wins over a simultaneous branch
    set_ctl(0, 1, 1, 0, 32'h0000_0100, 32'h0);
    tick();
    chk("j.npc", bus.npc, 32'h0000_0100);
    check_model("j");
    set_ctl(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("j2.pc", bus.pc, 32'h0000_0100);

    // Misaligned jump register wins over jump
    set_ctl(0, 0, 1, 1, 32'h0000_0200, 32'h0040_0023);
    tick();
    chk("jr.npc", bus.npc, 32'h0040_0020);
    chk("jr.addr_error", {31'd0, bus.addr_error}, 32'd1);
    chk("jr.redirect", {31'd0, bus.redirect}, 32'd1);
    set_ctl(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("jr2.addr_error", {31'd0, bus.addr_error}, 32'd0);
    check_model("jr2");

    // Stall with jump asserted holds state
    set_ctl(1, 0, 1, 0, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_model("stall");
    end
    reset = 0;
    tick();
    chk("stall_rst.pc", bus.pc, 32'h0040_0000);
    check_model("stall_rst");
    reset = 1;
    set_ctl(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("resume.pc", bus.pc, 32'h0040_0004);
    check_model("resume");

    // Randomized control traffic
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      set_ctl(($urandom_range(0, 4) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0),
              $urandom(),
              $urandom());
      tick();
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
